// File: rtl/fetch_unit_if.sv
// Instruction-cache request/response bus between the fetch stage and the icache.
// The fetch stage is the master: it drives the read request and address.
interface fetch_unit_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;

  modport master (
    output imemREN, imemaddr,
    input  ihit, imemload
  );

  modport slave (
    input  imemREN, imemaddr,
    output ihit, imemload
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the icache, feeds the IF/ID latch.
// Define FETCH_SKID_EN to add a one-entry skid buffer for hits under stall.
module fetch_unit #(
  parameter logic [31:0] PC0 = 32'h0000_0000
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_pc,
  input  logic         halt,
  fetch_unit_if.master imem,
  output logic [31:0]  instr,
  output logic [31:0]  curr_pc,
  output logic [31:0]  npc,
  output logic         ifid_en,
  output logic         ifid_flush
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    DROP = 2'd1,
    HALT = 2'd2
  } fsm_t;

  fsm_t        fsm_q, fsm_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        ren;
  logic [31:0] addr;

`ifdef FETCH_SKID_EN
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
`endif

  assign imem.imemREN  = ren;
  assign imem.imemaddr = addr;

  always_comb begin
    pc_d       = pc_q;
    fsm_d      = fsm_q;
    target_d   = target_q;
    ren        = 1'b0;
    addr       = pc_q;
    instr      = imem.imemload;
    curr_pc    = pc_q;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
`ifdef FETCH_SKID_EN
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
`endif
    if (!nRST) begin
      addr       = PC0;
      instr      = '0;
      curr_pc    = PC0;
      ifid_flush = 1'b1;
    end else if (halt) begin
      // Halt outranks redirect and fetch; nothing is captured or flushed.
      fsm_d = HALT;
`ifdef FETCH_SKID_EN
      skid_valid_d = 1'b0;
`endif
    end else begin
      unique case (fsm_q)
        RUN: begin
`ifdef FETCH_SKID_EN
          if (skid_valid_q) begin
            instr   = skid_instr_q;
            curr_pc = skid_pc_q;
            if (redirect_valid) begin
              ifid_flush   = 1'b1;
              skid_valid_d = 1'b0;
              pc_d         = redirect_pc;
            end else if (!stall) begin
              ifid_en      = 1'b1;
              skid_valid_d = 1'b0;
            end
          end else
`endif
          begin
            ren = 1'b1;
            if (redirect_valid) begin
              ifid_flush = 1'b1;
              // A blocking icache must keep its address until the miss ends.
              if (imem.ihit) begin
                pc_d = redirect_pc;
              end else begin
                target_d = redirect_pc;
                fsm_d    = DROP;
              end
            end else if (imem.ihit && !stall) begin
              ifid_en = 1'b1;
              pc_d    = pc_q + 32'd4;
            end
`ifdef FETCH_SKID_EN
            else if (imem.ihit) begin
              skid_valid_d = 1'b1;
              skid_instr_d = imem.imemload;
              skid_pc_d    = pc_q;
              pc_d         = pc_q + 32'd4;
            end
`endif
          end
        end
        DROP: begin
          ren = 1'b1;
          if (redirect_valid) begin
            target_d   = redirect_pc;
            ifid_flush = 1'b1;
          end
          if (imem.ihit) begin
            pc_d  = redirect_valid ? redirect_pc : target_q;
            fsm_d = RUN;
          end
        end
        HALT: begin
          fsm_d = HALT;
        end
        default: begin
          fsm_d = RUN;
        end
      endcase
    end
    npc = curr_pc + 32'd4;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      pc_q     <= PC0;
      fsm_q    <= RUN;
      target_q <= '0;
`ifdef FETCH_SKID_EN
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
`endif
    end else begin
      pc_q     <= pc_d;
      fsm_q    <= fsm_d;
      target_q <= target_d;
`ifdef FETCH_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
`endif
    end
  end

endmodule
